// File: rtl/busca_instrucao_pkg.sv
// Shared types and defaults for the instruction-fetch stage.
package pkg_busca;

  typedef enum logic [1:0] {OCIOSO, BUSCA, CHEIO} estado_busca_t;

  localparam int LARG_PADRAO = 16;

endpackage

// File: rtl/busca_instrucao_contador_pc.sv
// Program counter register: async reset to PC_RESET, load on redirect, step on capture.
module contador_pc #(
  parameter int          LARG       = 16,
  parameter logic [LARG-1:0] PC_RESET = '0,
  parameter int unsigned INCREMENTO = 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            carrega,
  input  logic            incrementa,
  input  logic [LARG-1:0] valor_carga,
  output logic [LARG-1:0] pc
);

  logic [LARG-1:0] pc_q, pc_d;

  // Redirect wins over the sequential step; the sum wraps modulo 2^LARG.
  always_comb begin
    pc_d = pc_q;
    if (carrega) begin
      pc_d = valor_carga;
    end else if (incrementa) begin
      pc_d = pc_q + LARG'(INCREMENTO);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_q <= PC_RESET;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/busca_instrucao.sv
// Instruction-fetch stage: owns the PC, fetches one word per request, hands it to decode.
// Optional IF_PC_COPIA_EN adds the pc_copia return-address output.
module busca_instrucao
  import pkg_busca::*;
#(
  parameter int              LARG       = LARG_PADRAO,
  parameter logic [LARG-1:0] PC_RESET   = '0,
  parameter int unsigned     INCREMENTO = 1
) (
  input  logic            clock,
  input  logic            reset,
  output logic            mem_req,
  output logic [LARG-1:0] mem_endereco,
  input  logic            mem_pronto,
  input  logic [LARG-1:0] mem_dado,
  input  logic            salto,
  input  logic [LARG-1:0] endereco_salto,
  input  logic            id_aceita,
  output logic            valido,
  output logic [LARG-1:0] instrucao,
  output logic [LARG-1:0] pc_instrucao
`ifdef IF_PC_COPIA_EN
  ,
  output logic [LARG-1:0] pc_copia
`endif
);

  estado_busca_t   estado_q, estado_d;
  logic            valido_q, valido_d;
  logic [LARG-1:0] instrucao_q, instrucao_d;
  logic [LARG-1:0] pc_instrucao_q, pc_instrucao_d;
  logic [LARG-1:0] pc;
  logic            captura;

  assign captura = (estado_q == BUSCA) && mem_pronto && !salto;

  contador_pc #(
    .LARG       (LARG),
    .PC_RESET   (PC_RESET),
    .INCREMENTO (INCREMENTO)
  ) u_contador_pc (
    .clock       (clock),
    .reset       (reset),
    .carrega     (salto),
    .incrementa  (captura),
    .valor_carga (endereco_salto),
    .pc          (pc)
  );

  always_comb begin
    estado_d       = estado_q;
    valido_d       = valido_q;
    instrucao_d    = instrucao_q;
    pc_instrucao_d = pc_instrucao_q;
    mem_req        = 1'b0;
    unique case (estado_q)
      OCIOSO: estado_d = BUSCA;
      BUSCA: begin
        mem_req = 1'b1;
        if (captura) begin
          instrucao_d    = mem_dado;
          pc_instrucao_d = pc;
          valido_d       = 1'b1;
          estado_d       = CHEIO;
        end
      end
      CHEIO: begin
        if (id_aceita) begin
          valido_d = 1'b0;
          estado_d = BUSCA;
        end
      end
      default: estado_d = OCIOSO;
    endcase
    // A redirect flushes whatever is held and overrides any same-cycle capture or accept.
    if (salto) begin
      valido_d = 1'b0;
      estado_d = BUSCA;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q       <= OCIOSO;
      valido_q       <= 1'b0;
      instrucao_q    <= '0;
      pc_instrucao_q <= '0;
    end else begin
      estado_q       <= estado_d;
      valido_q       <= valido_d;
      instrucao_q    <= instrucao_d;
      pc_instrucao_q <= pc_instrucao_d;
    end
  end

`ifdef IF_PC_COPIA_EN
  logic [LARG-1:0] pc_copia_q, pc_copia_d;

  always_comb begin
    pc_copia_d = pc_copia_q;
    if (captura) begin
      pc_copia_d = pc + LARG'(INCREMENTO);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_copia_q <= '0;
    end else begin
      pc_copia_q <= pc_copia_d;
    end
  end

  assign pc_copia = pc_copia_q;
`endif

  assign mem_endereco = pc;
  assign valido       = valido_q;
  assign instrucao    = instrucao_q;
  assign pc_instrucao = pc_instrucao_q;

endmodule

// File: tb/tb_busca_instrucao.sv
// Directed bench for busca_instrucao; a second instance covers PC wrap-around at 16'hFFFF.
module tb_busca_instrucao;

  logic        clock = 1'b0;
  logic        reset = 1'b1;

  logic        mem_req_a, mem_pronto_a, salto_a, id_aceita_a, valido_a;
  logic [15:0] mem_endereco_a, mem_dado_a, endereco_salto_a, instrucao_a, pc_instrucao_a;
  logic        zero_wait = 1'b0;
  logic        pronto_manual = 1'b0;

  logic        mem_req_b, valido_b;
  logic [15:0] mem_endereco_b, instrucao_b, pc_instrucao_b;

`ifdef IF_PC_COPIA_EN
  logic [15:0] pc_copia_a, pc_copia_b;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  // Memory model: data is address XOR A5A5; ready is immediate or bench-driven.
  assign mem_dado_a   = mem_endereco_a ^ 16'hA5A5;
  assign mem_pronto_a = zero_wait ? mem_req_a : pronto_manual;

  busca_instrucao #(
    .LARG       (16),
    .PC_RESET   (16'h0000),
    .INCREMENTO (1)
  ) dut_a (
    .clock          (clock),
    .reset          (reset),
    .mem_req        (mem_req_a),
    .mem_endereco   (mem_endereco_a),
    .mem_pronto     (mem_pronto_a),
    .mem_dado       (mem_dado_a),
    .salto          (salto_a),
    .endereco_salto (endereco_salto_a),
    .id_aceita      (id_aceita_a),
    .valido         (valido_a),
    .instrucao      (instrucao_a),
    .pc_instrucao   (pc_instrucao_a)
`ifdef IF_PC_COPIA_EN
    ,
    .pc_copia       (pc_copia_a)
`endif
  );

  busca_instrucao #(
    .LARG       (16),
    .PC_RESET   (16'hFFFF),
    .INCREMENTO (1)
  ) dut_b (
    .clock          (clock),
    .reset          (reset),
    .mem_req        (mem_req_b),
    .mem_endereco   (mem_endereco_b),
    .mem_pronto     (mem_req_b),
    .mem_dado       (mem_endereco_b ^ 16'hA5A5),
    .salto          (1'b0),
    .endereco_salto (16'h0000),
    .id_aceita      (1'b1),
    .valido         (valido_b),
    .instrucao      (instrucao_b),
    .pc_instrucao   (pc_instrucao_b)
`ifdef IF_PC_COPIA_EN
    ,
    .pc_copia       (pc_copia_b)
`endif
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    salto_a          = 1'b0;
    endereco_salto_a = 16'h0000;
    id_aceita_a      = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_mem_req", {15'd0, mem_req_a}, 16'h0000);
    chk("rst_valido", {15'd0, valido_a}, 16'h0000);
    chk("rst_instrucao", instrucao_a, 16'h0000);
    chk("rst_pc_instrucao", pc_instrucao_a, 16'h0000);
    chk("rst_endereco", mem_endereco_a, 16'h0000);
    chk("rst_endereco_b", mem_endereco_b, 16'hFFFF);

    // Test 1: zero-wait memory, decode always accepting
    zero_wait   = 1'b1;
    id_aceita_a = 1'b1;
    reset       = 1'b0;
    tick();
    chk("t1_ocioso_bubble_req", {15'd0, mem_req_a}, 16'h0001);
    chk("t1_ocioso_bubble_valido", {15'd0, valido_a}, 16'h0000);
    chk("t5_req_b", {15'd0, mem_req_b}, 16'h0001);
    chk("t5_end_b", mem_endereco_b, 16'hFFFF);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t1_valido_hi", {15'd0, valido_a}, 16'h0001);
      chk("t1_pc_instrucao", pc_instrucao_a, 16'(k));
      chk("t1_instrucao", instrucao_a, 16'(k) ^ 16'hA5A5);
      chk("t1_req_lo", {15'd0, mem_req_a}, 16'h0000);
      if (k == 0) begin
        chk("t5_valido_b", {15'd0, valido_b}, 16'h0001);
        chk("t5_pc_instrucao_b", pc_instrucao_b, 16'hFFFF);
        chk("t5_instrucao_b", instrucao_b, 16'h5A5A);
        chk("t5_wrap_end_b", mem_endereco_b, 16'h0000);
`ifdef IF_PC_COPIA_EN
        chk("t5_pc_copia_b", pc_copia_b, 16'h0000);
`endif
      end
      tick();
      chk("t1_valido_lo", {15'd0, valido_a}, 16'h0000);
      chk("t1_next_end", mem_endereco_a, 16'(k + 1));
    end

    // Test 2: memory answers only on the fourth request cycle at 0x0004
    zero_wait     = 1'b0;
    pronto_manual = 1'b0;
    id_aceita_a   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t2_req_stable", {15'd0, mem_req_a}, 16'h0001);
      chk("t2_end_stable", mem_endereco_a, 16'h0004);
      chk("t2_no_capture", {15'd0, valido_a}, 16'h0000);
    end
    pronto_manual = 1'b1;
    tick();
    pronto_manual = 1'b0;
    chk("t2_valido", {15'd0, valido_a}, 16'h0001);
    chk("t2_pc_instrucao", pc_instrucao_a, 16'h0004);
    chk("t2_instrucao", instrucao_a, 16'hA5A1);
    chk("t2_pc_next", mem_endereco_a, 16'h0005);

    // Test 3: held instruction while decode stalls
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t3_valido_held", {15'd0, valido_a}, 16'h0001);
      chk("t3_instrucao_held", instrucao_a, 16'hA5A1);
      chk("t3_pc_instrucao_held", pc_instrucao_a, 16'h0004);
      chk("t3_req_lo", {15'd0, mem_req_a}, 16'h0000);
    end
    id_aceita_a = 1'b1;
    tick();
    chk("t3_accept_valido", {15'd0, valido_a}, 16'h0000);
    chk("t3_accept_req", {15'd0, mem_req_a}, 16'h0001);

    // Walk to a request at 0x0007
    pronto_manual = 1'b1;  tick();
    pronto_manual = 1'b0;  tick();
    pronto_manual = 1'b1;  tick();
    chk("t4_pre_pc_instrucao", pc_instrucao_a, 16'h0006);
    pronto_manual = 1'b0;  tick();
    chk("t4_pre_end", mem_endereco_a, 16'h0007);
    chk("t4_pre_req", {15'd0, mem_req_a}, 16'h0001);
`ifdef IF_PC_COPIA_EN
    chk("t4_pre_pc_copia", pc_copia_a, 16'h0007);
`endif

    // Test 4: redirect in the same cycle as mem_pronto
    pronto_manual    = 1'b1;
    salto_a          = 1'b1;
    endereco_salto_a = 16'h0100;
    tick();
    salto_a       = 1'b0;
    pronto_manual = 1'b0;
    chk("t4_valido", {15'd0, valido_a}, 16'h0000);
    chk("t4_no_capture_pc", pc_instrucao_a, 16'h0006);
    chk("t4_no_capture_instr", instrucao_a, 16'hA5A3);
    chk("t4_end", mem_endereco_a, 16'h0100);
    chk("t4_req", {15'd0, mem_req_a}, 16'h0001);

    // Redirect while CHEIO with id_aceita flushes the held word
    pronto_manual = 1'b1;
    tick();
    pronto_manual = 1'b0;
    chk("t4b_capture", pc_instrucao_a, 16'h0100);
    salto_a          = 1'b1;
    endereco_salto_a = 16'h0200;
    tick();
    salto_a = 1'b0;
    chk("t4b_flush_valido", {15'd0, valido_a}, 16'h0000);
    chk("t4b_end", mem_endereco_a, 16'h0200);
    chk("t4b_req", {15'd0, mem_req_a}, 16'h0001);
`ifdef IF_PC_COPIA_EN
    chk("t4b_pc_copia_hold", pc_copia_a, 16'h0101);
`endif

    // Test 6: async reset while a request is outstanding
    #2;
    reset = 1'b1;
    #1;
    chk("t6_req_drop", {15'd0, mem_req_a}, 16'h0000);
    chk("t6_valido", {15'd0, valido_a}, 16'h0000);
    chk("t6_end", mem_endereco_a, 16'h0000);
    chk("t6_instrucao", instrucao_a, 16'h0000);
`ifdef IF_PC_COPIA_EN
    chk("t6_pc_copia", pc_copia_a, 16'h0000);
`endif
    tick();
    reset = 1'b0;
    tick();
    chk("t6_restart_req", {15'd0, mem_req_a}, 16'h0001);
    chk("t6_restart_end", mem_endereco_a, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
